sd_data_output: RTL and testbench

Read-back path for the SD card logger. On a start request it reads `SECTOR_CNT` consecutive sectors through the SD reader master and keeps the low byte of each 16-bit word (the write path stores one byte per word, upper byte zero). The bytes are buffered in an internal FIFO and paced out to the UART transmitter as one-cycle `tx_flag` strobes. It sits beside the SD write-side input block, sharing the SD controller's read port.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_data_output_if.sv | 13 +
 rtl/sd_data_output_fifo.sv | 53 +++++
 rtl/sd_data_output.sv | 124 ++++++++++++
 tb/tb_sd_data_output.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Constants and FSM encoding shared by the SD logger read-back and write-side blocks.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_READ      = 3'd3,
    ST_NEXT      = 3'd4,
    ST_DRAIN     = 3'd5
  } sd_state_t;

  localparam int          SD_DATA_NUM = 256;
  localparam logic [15:0] SD_TX_GAP   = 16'd60000;

  // A requested sector count of zero still reads one sector.
  function automatic logic [15:0] sectors_eff(input logic [15:0] cnt);
    return (cnt == 16'd0) ? 16'd1 : cnt;
  endfunction

endpackage

// File: rtl/sd_data_output_if.sv
// Read port of the SD reader master: one-cycle request, busy window, word strobes.
interface sd_data_output_if #(
  parameter int ADDR_W = 32
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic              rd_data_en;
  logic [15:0]       rd_data;

  modport master (output rd_en, rd_addr, input rd_busy, rd_data_en, rd_data);
  modport slave  (input rd_en, rd_addr, output rd_busy, rd_data_en, rd_data);
endinterface

// File: rtl/sd_data_output_fifo.sv
// Byte FIFO with registered read data; the storage array carries no reset so it maps to block RAM.
module sync_byte_fifo #(
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    dout_reg;
  logic          do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign dout    = dout_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= 8'd0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        dout_reg   <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/sd_data_output.sv
// Reads consecutive SD sectors, keeps the low byte of each word and paces the bytes out to the UART.
module sd_data_output
  import sd_pkg::*;
#(
  parameter int          DATA_NUM   = SD_DATA_NUM,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [15:0] TX_GAP     = SD_TX_GAP,
  parameter int          ADDR_W     = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [15:0]          sector_cnt,
  input  logic                 init_end,
  sd_data_output_if.master     rd,
  output logic                 tx_flag,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sd_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [15:0]       sec_total_reg, sec_done_reg, word_cnt_reg, cnt_wait_reg;
  logic              rd_en_reg, rd_en_next, rd_busy_d_reg, err_reg, tx_flag_reg;
  logic              accept, push, pop, busy_fall, space_ok, last_sector, drain_idle;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        fifo_dout;

  assign accept      = (state_reg == ST_IDLE) && start && init_end;
  assign space_ok    = (FIFO_DEPTH - int'(fifo_count)) >= DATA_NUM;
  assign busy_fall   = rd_busy_d_reg && !rd.rd_busy;
  assign push        = (state_reg == ST_READ) && rd.rd_data_en && (word_cnt_reg < 16'(DATA_NUM));
  assign pop         = (cnt_wait_reg == TX_GAP - 16'd1) && !fifo_empty;
  assign last_sector = (sec_done_reg + 16'd1) >= sec_total_reg;
  // Nothing left in the FIFO, no pop scheduled and no strobe on the wire.
  assign drain_idle  = fifo_empty && (cnt_wait_reg == 16'd0) && !tx_flag_reg;

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .din   (rd.rd_data[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (accept)      state_next = ST_REQ;
      ST_REQ:       if (space_ok)    state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (rd.rd_busy)  state_next = ST_READ;
      ST_READ:      if (busy_fall)   state_next = ST_NEXT;
      ST_NEXT:      state_next = last_sector ? ST_DRAIN : ST_REQ;
      ST_DRAIN:     if (drain_idle)  state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en_next = (state_reg == ST_REQ) && space_ok;
    busy       = (state_reg != ST_IDLE);
    done       = (state_reg == ST_DRAIN) && drain_idle;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rd_en_reg     <= 1'b0;
      rd_busy_d_reg <= 1'b0;
      rd_addr_reg   <= '0;
      sec_total_reg <= 16'd0;
      sec_done_reg  <= 16'd0;
      word_cnt_reg  <= 16'd0;
      err_reg       <= 1'b0;
      cnt_wait_reg  <= 16'd0;
      tx_flag_reg   <= 1'b0;
    end else begin
      rd_en_reg     <= rd_en_next;
      rd_busy_d_reg <= rd.rd_busy;
      tx_flag_reg   <= pop;
      if (accept) begin
        rd_addr_reg   <= start_addr;
        sec_total_reg <= sectors_eff(sector_cnt);
        sec_done_reg  <= 16'd0;
        word_cnt_reg  <= 16'd0;
        err_reg       <= 1'b0;
      end
      if (state_reg == ST_READ) begin
        if (rd.rd_data_en) begin
          if (word_cnt_reg != 16'hFFFF) word_cnt_reg <= word_cnt_reg + 16'd1;
          if (!push) err_reg <= 1'b1;
        end
        if (busy_fall && (word_cnt_reg != 16'(DATA_NUM))) err_reg <= 1'b1;
      end
      if (state_reg == ST_NEXT) begin
        rd_addr_reg  <= rd_addr_reg + 1'b1;
        sec_done_reg <= sec_done_reg + 16'd1;
        word_cnt_reg <= 16'd0;
      end
      // The pacer free-runs once started so strobes stay TX_GAP apart.
      if (!fifo_empty || (cnt_wait_reg != 16'd0))
        cnt_wait_reg <= (cnt_wait_reg == TX_GAP - 16'd1) ? 16'd0 : cnt_wait_reg + 16'd1;
    end
  end

  assign rd.rd_en   = rd_en_reg;
  assign rd.rd_addr = rd_addr_reg;
  assign tx_flag    = tx_flag_reg;
  assign tx_data    = fifo_dout;
  assign err        = err_reg;
endmodule

// File: tb/tb_sd_data_output.sv
// Directed bench for sd_data_output with a small SD reader model and a UART strobe monitor.
module tb_sd_data_output;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = 32'd0;
  logic [15:0] sector_cnt = 16'd0;
  logic        init_end = 1'b0;
  logic        tx_flag, busy, done, err;
  logic [7:0]  tx_data;

  sd_data_output_if #(.ADDR_W(32)) rd ();

  sd_data_output #(
    .DATA_NUM   (4),
    .FIFO_DEPTH (4),
    .TX_GAP     (16'd4),
    .ADDR_W     (32)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .start_addr (start_addr),
    .sector_cnt (sector_cnt),
    .init_end   (init_end),
    .rd         (rd.master),
    .tx_flag    (tx_flag),
    .tx_data    (tx_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] txq[$];
  int         txc[$];
  int         rd_en_total = 0;

  always @(negedge sys_clk) begin
    if (tx_flag) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
    end
    if (rd.rd_en) rd_en_total++;
  end

  function automatic int tc(input int i);
    return (i < txc.size()) ? txc[i] : -1;
  endfunction

  function automatic logic [7:0] tq(input int i);
    return (i < txq.size()) ? txq[i] : 8'hXX;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] n, output int at);
    @(negedge sys_clk);
    start = 1'b1; start_addr = a; sector_cnt = n;
    at = cyc;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_rd(input logic [31:0] a, input string tag, output int at);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (rd.rd_en) begin
        found = 1'b1;
        break;
      end
    end
    at = cyc;
    chk($sformatf("%s_rd_en", tag), 32'(found), 32'd1);
    if (found) chk($sformatf("%s_rd_addr", tag), rd.rd_addr, a);
  endtask

  // Called on the rd_en cycle: raise busy, stream n words, drop busy, settle one cycle.
  task automatic serve(input int n, input logic [15:0] base, input logic [15:0] step, output int first);
    rd.rd_busy = 1'b1;
    first = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      rd.rd_data_en = 1'b1;
      rd.rd_data = base + step * 16'(i);
      if (i == 0) first = cyc;
    end
    @(negedge sys_clk);
    rd.rd_data_en = 1'b0;
    rd.rd_busy = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_done(input string tag, output int at);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    at = cyc;
    chk($sformatf("%s_done", tag), 32'(found), 32'd1);
    @(negedge sys_clk);
    chk($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
  endtask

  initial begin
    int st, rq, k, dn, base_en;
    rd.rd_busy = 1'b0; rd.rd_data_en = 1'b0; rd.rd_data = 16'd0;

    // Reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_rd_en", 32'(rd.rd_en), 32'd0);
    chk("rst_rd_addr", rd.rd_addr, 32'd0);
    chk("rst_tx_flag", 32'(tx_flag), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    sys_rst_n = 1'b1;
    init_end = 1'b1;

    // Single sector
    do_start(32'd1000, 16'd1, st);
    wait_rd(32'd1000, "s1", rq);
    chk("s1_start_to_rd_en", 32'(rq - st), 32'd2);
    serve(4, 16'h0011, 16'h0011, k);
    wait_done("s1", dn);
    chk("s1_count", 32'(txq.size()), 32'd4);
    chk("s1_b0", 32'(tq(0)), 32'h11);
    chk("s1_b1", 32'(tq(1)), 32'h22);
    chk("s1_b2", 32'(tq(2)), 32'h33);
    chk("s1_b3", 32'(tq(3)), 32'h44);
    chk("s1_first_strobe", 32'(tc(0) - k), 32'd5);
    for (int i = 1; i < 4; i++) chk($sformatf("s1_gap%0d", i), 32'(tc(i) - tc(i-1)), 32'd4);
    chk("s1_done_after_last", 32'(dn - tc(3)), 32'd1);
    chk("s1_err", 32'(err), 32'd0);
    chk("s1_busy_end", 32'(busy), 32'd0);
    chk("s1_rd_en_total", 32'(rd_en_total), 32'd1);
    txq.delete(); txc.delete();

    // Multi-sector with a FIFO only one sector deep
    do_start(32'd1000, 16'd3, st);
    for (int s = 0; s < 3; s++) begin
      wait_rd(32'd1000 + 32'(s), $sformatf("ms%0d", s), rq);
      chk($sformatf("ms%0d_bytes_before_req", s), 32'(txq.size()), 32'(4 * s));
      if (s > 0) chk($sformatf("ms%0d_req_after_drain", s), 32'(rq - tc(4*s - 1)), 32'd1);
      serve(4, 16'hA501 + 16'(16 * s), 16'd1, k);
    end
    wait_done("ms", dn);
    chk("ms_count", 32'(txq.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("ms_b%0d", i), 32'(tq(i)), 32'((i / 4) * 16 + (i % 4) + 1));
    chk("ms_err", 32'(err), 32'd0);
    txq.delete(); txc.delete();

    // Short sector
    do_start(32'd2000, 16'd1, st);
    wait_rd(32'd2000, "sh", rq);
    serve(3, 16'h0031, 16'd1, k);
    chk("sh_err", 32'(err), 32'd1);
    wait_done("sh", dn);
    chk("sh_count", 32'(txq.size()), 32'd3);
    chk("sh_b2", 32'(tq(2)), 32'h33);
    txq.delete(); txc.delete();

    // Long sector: start clears err, 5th word dropped
    do_start(32'd3000, 16'd1, st);
    wait_rd(32'd3000, "lg", rq);
    chk("lg_err_cleared", 32'(err), 32'd0);
    serve(5, 16'h0041, 16'd1, k);
    chk("lg_err", 32'(err), 32'd1);
    wait_done("lg", dn);
    chk("lg_count", 32'(txq.size()), 32'd4);
    chk("lg_b3", 32'(tq(3)), 32'h44);
    txq.delete(); txc.delete();

    // Gating: start without init_end, then start while busy
    base_en = rd_en_total;
    init_end = 1'b0;
    do_start(32'd5000, 16'd1, st);
    repeat (20) @(negedge sys_clk);
    chk("gate_init_rd_en", 32'(rd_en_total), 32'(base_en));
    chk("gate_init_busy", 32'(busy), 32'd0);
    init_end = 1'b1;
    do_start(32'd6000, 16'd1, st);
    wait_rd(32'd6000, "gb", rq);
    serve(4, 16'h0061, 16'd1, k);
    do_start(32'd7000, 16'd1, st);
    chk("gb_busy_after_start", 32'(busy), 32'd1);
    chk("gb_addr_kept", rd.rd_addr, 32'd6001);
    wait_done("gb", dn);
    repeat (20) @(negedge sys_clk);
    chk("gb_rd_en_total", 32'(rd_en_total), 32'(base_en + 1));
    chk("gb_count", 32'(txq.size()), 32'd4);
    chk("gb_busy_end", 32'(busy), 32'd0);
    txq.delete(); txc.delete();

    // Reset in the middle of READ
    base_en = rd_en_total;
    do_start(32'd8000, 16'd1, st);
    wait_rd(32'd8000, "rr", rq);
    rd.rd_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      rd.rd_data_en = 1'b1; rd.rd_data = 16'h0081 + 16'(i);
    end
    @(negedge sys_clk);
    rd.rd_data_en = 1'b0;
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_rd_en", 32'(rd.rd_en), 32'd0);
    chk("rr_rd_addr", rd.rd_addr, 32'd0);
    chk("rr_tx_flag", 32'(tx_flag), 32'd0);
    chk("rr_tx_data", 32'(tx_data), 32'd0);
    chk("rr_err", 32'(err), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    @(negedge sys_clk);
    rd.rd_data_en = 1'b1; rd.rd_data = 16'h00EE;
    @(negedge sys_clk);
    rd.rd_data_en = 1'b0; rd.rd_busy = 1'b0;
    repeat (30) @(negedge sys_clk);
    chk("rr_no_tx", 32'(txq.size()), 32'd0);
    chk("rr_idle", 32'(busy), 32'd0);
    chk("rr_rd_en_total", 32'(rd_en_total), 32'(base_en + 1));
    do_start(32'd9000, 16'd1, st);
    wait_rd(32'd9000, "rn", rq);
    serve(4, 16'h0091, 16'd1, k);
    wait_done("rn", dn);
    chk("rn_count", 32'(txq.size()), 32'd4);
    chk("rn_b0", 32'(tq(0)), 32'h91);
    chk("rn_b3", 32'(tq(3)), 32'h94);
    chk("rn_err", 32'(err), 32'd0);
    txq.delete(); txc.delete();

    // Address wrap
    do_start(32'hFFFF_FFFF, 16'd2, st);
    wait_rd(32'hFFFF_FFFF, "wr0", rq);
    serve(4, 16'h00C1, 16'd1, k);
    wait_rd(32'h0000_0000, "wr1", rq);
    serve(4, 16'h00D1, 16'd1, k);
    wait_done("wr", dn);
    chk("wr_count", 32'(txq.size()), 32'd8);
    chk("wr_b4", 32'(tq(4)), 32'hD1);
    chk("wr_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
